alu_driver: RTL and testbench
=============================

# alu_driver

Command front-end for the registered 4-bit ALU. It accepts one operation at a time over a valid/ready command port, drives the ALU operand and opcode inputs, and waits the ALU's fixed pipeline latency. It then captures the 8-bit result and returns it over a valid/ready response port. It sits between a command source (bench sequencer or control FSM) and the ALU, and keeps exactly one operation in flight.

## Interface
- LAT, 2, ALU latency: rising edges from the ALU sampling its inputs to `out` updating, including the sampling edge (input reg + output reg = 2).
- TXN_W, 8, width of the completed-transaction counter.

- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- cmd_valid  in  1  command offered
- cmd_ready  out  1  command accepted when high with cmd_valid
- cmd_a  in  4  operand A
- cmd_b  in  4  operand B
- cmd_op  in  2  00 add, 01 mul, 10 or, 11 and
- alu_a  out  4  to ALU `a`, registered
- alu_b  out  4  to ALU `b`, registered
- alu_op  out  2  to ALU `op`, registered
- alu_out  in  8  from ALU `out`
- rsp_valid  out  1  result available
- rsp_ready  in  1  consumer takes result
- rsp_data  out  8  captured result
- rsp_op  out  2  opcode of that result
- rsp_err  out  1  result mismatch (see Configuration)
- busy  out  1  state != IDLE
- txn_cnt  out  TXN_W  completed responses, wraps modulo 2^TXN_W

## Operation
- States: IDLE, WAIT, RESP.
- IDLE: cmd_ready=1. On cmd_valid:
  - register cmd_a/b/op onto alu_a/b/op
  - load wait counter with LAT
  - go to WAIT.
- WAIT: cmd_ready=0. Counter decrements each edge while nonzero. On the edge where the counter is already 0:
  - capture alu_out into rsp_data, and alu_op into rsp_op
  - compute rsp_err
  - go to RESP.
- RESP: rsp_valid=1. rsp_data, rsp_op and rsp_err are held stable until handshake (rsp_valid & rsp_ready). On handshake, txn_cnt increments and the state goes to IDLE.
- Overlap: cmd_ready = (state==IDLE) | (state==RESP & rsp_ready). A command accepted in the same cycle as the response handshake goes directly to WAIT with the counter reloaded.
- alu_a/b/op change only on command accept. They are held through WAIT and RESP.
- cmd_valid while not ready is ignored. The source holds it.
- txn_cnt wraps from all-ones to 0 with no flag.

## Timing
- Command accepted at edge T:
  - alu_a/b/op valid after T
  - ALU samples them at T+1
  - alu_out valid after T+2 (LAT=2)
  - captured at T+LAT+1
  - rsp_valid high after T+LAT+1.
- With rsp_ready tied high, the response handshake is at T+LAT+2 and the next accept is at the same edge. Sustained throughput is one operation per LAT+2 cycles.
- Reset values: cmd_ready=0 while rst is asserted, 1 after release (IDLE). All other outputs are 0: alu_a, alu_b, alu_op, rsp_valid, rsp_data, rsp_op, rsp_err, busy, txn_cnt.
- Reset mid-WAIT or mid-RESP: the state returns to IDLE immediately and the pending result is discarded. The ALU shares rst, so no stale result is captured after release.

## Configuration
- ALU_DRV_CHECK_EN defined:
  - A golden model is computed from the accepted operands:
    - add = 5-bit sum, zero-extended
    - mul = 8-bit product
    - or / and = 4-bit result, zero-extended
  - rsp_err = (alu_out != expected), registered with the capture.
- ALU_DRV_CHECK_EN undefined: no model logic, and rsp_err is tied 0.

## Test plan
- Reset, then cmd 3+5 (op 00), rsp_ready=1 -> rsp_valid exactly LAT+1 edges after accept, rsp_data=0x08, rsp_op=00, txn_cnt=1.
- Cmd 15*15 (op 01), then 0xA|0x5 (op 10), then 0xC&0x6 (op 11), back-to-back with rsp_ready=1 -> rsp_data 0xE1, 0x0F, 0x04; accepts 4 cycles apart.
- Cmd 15+15, rsp_ready=0 for 6 cycles -> rsp_data=0x1E held stable, cmd_ready=0, alu_a/b/op unchanged; releasing rsp_ready gives a handshake and simultaneous next accept.
- With ALU_DRV_CHECK_EN, force alu_out=0x00 on cmd 2*3 -> rsp_err=1; unforced -> rsp_err=0. Without the macro, rsp_err is always 0.
- Assert rst one cycle after accepting cmd 7+1 -> all outputs return to reset values, no rsp_valid follows; next cmd 1+1 returns 0x02.
- 256 transactions -> txn_cnt wraps to 0.

Source files
------------

// File: rtl/alu_driver_if.sv
// Command/response/ALU bundle for alu_driver: the slave modport is the driver itself,
// the master modport is the command source plus the ALU it talks to.
interface alu_driver_if #(
  parameter int TXN_W = 8
);
  logic             cmd_valid;
  logic             cmd_ready;
  logic [3:0]       cmd_a;
  logic [3:0]       cmd_b;
  logic [1:0]       cmd_op;
  logic [3:0]       alu_a;
  logic [3:0]       alu_b;
  logic [1:0]       alu_op;
  logic [7:0]       alu_out;
  logic             rsp_valid;
  logic             rsp_ready;
  logic [7:0]       rsp_data;
  logic [1:0]       rsp_op;
  logic             rsp_err;
  logic             busy;
  logic [TXN_W-1:0] txn_cnt;

  modport slave (
    input  cmd_valid, cmd_a, cmd_b, cmd_op, alu_out, rsp_ready,
    output cmd_ready, alu_a, alu_b, alu_op, rsp_valid, rsp_data, rsp_op, rsp_err,
           busy, txn_cnt
  );

  modport master (
    output cmd_valid, cmd_a, cmd_b, cmd_op, alu_out, rsp_ready,
    input  cmd_ready, alu_a, alu_b, alu_op, rsp_valid, rsp_data, rsp_op, rsp_err,
           busy, txn_cnt
  );
endinterface

// File: rtl/alu_driver.sv
// Single-outstanding command front-end for the registered 4-bit ALU.
// Define ALU_DRV_CHECK_EN to build the golden-model result checker that drives rsp_err.
module alu_driver #(
  parameter int LAT   = 2,
  parameter int TXN_W = 8
) (
  input logic         clk,
  input logic         rst,
  alu_driver_if.slave bus
);

  localparam int CW = (LAT < 1) ? 1 : $clog2(LAT + 1);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [3:0]       alu_a_q, alu_a_d;
  logic [3:0]       alu_b_q, alu_b_d;
  logic [1:0]       alu_op_q, alu_op_d;
  logic [7:0]       rsp_data_q, rsp_data_d;
  logic [1:0]       rsp_op_q, rsp_op_d;
  logic [TXN_W-1:0] txn_q, txn_d;
  logic             ready_int;
  logic             accept;
  logic             capture;

  // A response slot frees up in the same cycle it is consumed, so RESP can accept too.
  assign ready_int = (state_q == IDLE) || ((state_q == RESP) && bus.rsp_ready);
  assign accept    = ready_int && bus.cmd_valid;
  assign capture   = (state_q == WAIT) && (cnt_q == '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      alu_a_q    <= '0;
      alu_b_q    <= '0;
      alu_op_q   <= '0;
      rsp_data_q <= '0;
      rsp_op_q   <= '0;
      txn_q      <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      alu_a_q    <= alu_a_d;
      alu_b_q    <= alu_b_d;
      alu_op_q   <= alu_op_d;
      rsp_data_q <= rsp_data_d;
      rsp_op_q   <= rsp_op_d;
      txn_q      <= txn_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    alu_a_d    = alu_a_q;
    alu_b_d    = alu_b_q;
    alu_op_d   = alu_op_q;
    rsp_data_d = rsp_data_q;
    rsp_op_d   = rsp_op_q;
    txn_d      = txn_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d  = WAIT;
          cnt_d    = CW'(LAT);
          alu_a_d  = bus.cmd_a;
          alu_b_d  = bus.cmd_b;
          alu_op_d = bus.cmd_op;
        end
      end
      WAIT: begin
        if (capture) begin
          state_d    = RESP;
          rsp_data_d = bus.alu_out;
          rsp_op_d   = alu_op_q;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      RESP: begin
        if (bus.rsp_ready) begin
          txn_d = txn_q + TXN_W'(1);
          if (accept) begin
            state_d  = WAIT;
            cnt_d    = CW'(LAT);
            alu_a_d  = bus.cmd_a;
            alu_b_d  = bus.cmd_b;
            alu_op_d = bus.cmd_op;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

`ifdef ALU_DRV_CHECK_EN
  logic [7:0] expected;
  logic       rsp_err_q;

  // Golden result from the operands currently held on the ALU inputs.
  always_comb begin
    expected = '0;
    case (alu_op_q)
      2'b00:   expected = {3'b000, {1'b0, alu_a_q} + {1'b0, alu_b_q}};
      2'b01:   expected = {4'b0000, alu_a_q} * {4'b0000, alu_b_q};
      2'b10:   expected = {4'b0000, alu_a_q | alu_b_q};
      default: expected = {4'b0000, alu_a_q & alu_b_q};
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rsp_err_q <= 1'b0;
    end else if (capture) begin
      rsp_err_q <= (bus.alu_out != expected);
    end
  end

  assign bus.rsp_err = rsp_err_q;
`else
  assign bus.rsp_err = 1'b0;
`endif

  // cmd_ready is gated by rst so a source never sees a ready that cannot be honoured.
  assign bus.cmd_ready = ready_int && !rst;
  assign bus.alu_a     = alu_a_q;
  assign bus.alu_b     = alu_b_q;
  assign bus.alu_op    = alu_op_q;
  assign bus.rsp_valid = (state_q == RESP);
  assign bus.rsp_data  = rsp_data_q;
  assign bus.rsp_op    = rsp_op_q;
  assign bus.busy      = (state_q != IDLE);
  assign bus.txn_cnt   = txn_q;

endmodule

// File: tb/tb_alu_driver.sv
// Directed bench for alu_driver with a behavioural two-stage ALU and a response scoreboard.
// The rsp_err expectation follows ALU_DRV_CHECK_EN.
module tb_alu_driver;

  localparam int LAT   = 2;
  localparam int TXN_W = 8;
`ifdef ALU_DRV_CHECK_EN
  localparam bit CHECK_ON = 1'b1;
`else
  localparam bit CHECK_ON = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic forceZero = 1'b0;
  logic [3:0] aluInA, aluInB;
  logic [1:0] aluInOp;
  logic [7:0] aluOutQ;
  int cycle = 0;
  int assertCount = 0;
  int failCount = 0;
  int acceptCycle = 0;
  int prevAccept = 0;
  logic [9:0] sb[$];

  alu_driver_if #(.TXN_W(TXN_W)) bus ();

  alu_driver #(.LAT(LAT), .TXN_W(TXN_W)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cycle <= cycle + 1;

  function automatic logic [7:0] model(input logic [3:0] a, input logic [3:0] b,
                                       input logic [1:0] op);
    case (op)
      2'b00:   return {3'b000, {1'b0, a} + {1'b0, b}};
      2'b01:   return {4'b0000, a} * {4'b0000, b};
      2'b10:   return {4'b0000, a | b};
      default: return {4'b0000, a & b};
    endcase
  endfunction

  // Behavioural ALU: input register then output register, sharing rst with the driver.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      aluInA  <= '0;
      aluInB  <= '0;
      aluInOp <= '0;
      aluOutQ <= '0;
    end else begin
      aluInA  <= bus.alu_a;
      aluInB  <= bus.alu_b;
      aluInOp <= bus.alu_op;
      aluOutQ <= model(aluInA, aluInB, aluInOp);
    end
  end

  assign bus.alu_out = forceZero ? 8'h00 : aluOutQ;

  task automatic checkOutput(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    assertCount++;
    assert (obs === exp)
    else begin
      failCount++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic checkResetValues(input string tag);
    checkOutput({tag, "_cmd_ready"}, 16'(bus.cmd_ready), 16'h0);
    checkOutput({tag, "_alu_a"},     16'(bus.alu_a),     16'h0);
    checkOutput({tag, "_alu_b"},     16'(bus.alu_b),     16'h0);
    checkOutput({tag, "_alu_op"},    16'(bus.alu_op),    16'h0);
    checkOutput({tag, "_rsp_valid"}, 16'(bus.rsp_valid), 16'h0);
    checkOutput({tag, "_rsp_data"},  16'(bus.rsp_data),  16'h0);
    checkOutput({tag, "_rsp_op"},    16'(bus.rsp_op),    16'h0);
    checkOutput({tag, "_rsp_err"},   16'(bus.rsp_err),   16'h0);
    checkOutput({tag, "_busy"},      16'(bus.busy),      16'h0);
    checkOutput({tag, "_txn_cnt"},   16'(bus.txn_cnt),   16'h0);
  endtask

  task automatic applyReset(input string tag);
    rst = 1'b1;
    bus.cmd_valid = 1'b0;
    repeat (2) @(negedge clk);
    checkResetValues(tag);
    sb.delete();
    rst = 1'b0;
    #1;
    checkOutput({tag, "_ready_after"}, 16'(bus.cmd_ready), 16'h1);
  endtask

  // Offers one command, pushes its expected result and returns just after the accepting edge.
  task automatic applyStimulus(input logic [3:0] a, input logic [3:0] b, input logic [1:0] op);
    int n;
    bus.cmd_valid = 1'b1;
    bus.cmd_a = a;
    bus.cmd_b = b;
    bus.cmd_op = op;
    sb.push_back({op, model(a, b, op)});
    #1;
    n = 0;
    while (!bus.cmd_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!bus.cmd_ready) checkOutput("accept_timeout", 16'(bus.cmd_ready), 16'h1);
    @(posedge clk);
    #1;
    prevAccept = acceptCycle;
    acceptCycle = cycle;
    bus.cmd_valid = 1'b0;
  endtask

  task automatic waitRsp(input string tag, input bit expErr);
    int n;
    logic [9:0] exp;
    n = 0;
    while (!bus.rsp_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    checkOutput({tag, "_rsp_valid"}, 16'(bus.rsp_valid), 16'h1);
    checkOutput({tag, "_latency"}, 16'(cycle - acceptCycle), 16'(LAT + 1));
    if (sb.size() == 0) begin
      checkOutput({tag, "_sb_empty"}, 16'(sb.size()), 16'h1);
    end else begin
      exp = sb.pop_front();
      checkOutput({tag, "_rsp_data"}, 16'(bus.rsp_data), forceZero ? 16'h0 : 16'(exp[7:0]));
      checkOutput({tag, "_rsp_op"}, 16'(bus.rsp_op), 16'(exp[9:8]));
      checkOutput({tag, "_rsp_err"}, 16'(bus.rsp_err), 16'(expErr));
    end
  endtask

  initial begin
    bus.cmd_valid = 1'b0;
    bus.cmd_a = '0;
    bus.cmd_b = '0;
    bus.cmd_op = '0;
    bus.rsp_ready = 1'b1;

    applyReset("reset0");

    // Single add, then the handshake bumps txn_cnt.
    applyStimulus(4'd3, 4'd5, 2'b00);
    waitRsp("add3p5", 1'b0);
    checkOutput("add3p5_value", 16'(bus.rsp_data), 16'h08);
    @(negedge clk);
    checkOutput("txn_after_first", 16'(bus.txn_cnt), 16'h1);
    checkOutput("idle_after_first", 16'(bus.busy), 16'h0);

    // Back-to-back mul/or/and with overlapped accept.
    applyStimulus(4'd15, 4'd15, 2'b01);
    waitRsp("mul15x15", 1'b0);
    applyStimulus(4'hA, 4'h5, 2'b10);
    checkOutput("b2b_gap1", 16'(acceptCycle - prevAccept), 16'(LAT + 2));
    waitRsp("or_a_5", 1'b0);
    applyStimulus(4'hC, 4'h6, 2'b11);
    checkOutput("b2b_gap2", 16'(acceptCycle - prevAccept), 16'(LAT + 2));
    waitRsp("and_c_6", 1'b0);
    checkOutput("and_c_6_value", 16'(bus.rsp_data), 16'h04);
    @(negedge clk);

    // Backpressure: response and ALU inputs hold while a new command is ignored.
    bus.rsp_ready = 1'b0;
    applyStimulus(4'd15, 4'd15, 2'b00);
    waitRsp("add15p15", 1'b0);
    bus.cmd_valid = 1'b1;
    bus.cmd_a = 4'd1;
    bus.cmd_b = 4'd2;
    bus.cmd_op = 2'b00;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      checkOutput("hold_data", 16'(bus.rsp_data), 16'h1E);
      checkOutput("hold_valid", 16'(bus.rsp_valid), 16'h1);
      checkOutput("hold_ready", 16'(bus.cmd_ready), 16'h0);
      checkOutput("hold_alu", {8'h0, bus.alu_a, bus.alu_b}, 16'hFF);
      checkOutput("hold_op", 16'(bus.alu_op), 16'h0);
    end
    bus.rsp_ready = 1'b1;
    #1;
    checkOutput("release_ready", 16'(bus.cmd_ready), 16'h1);
    applyStimulus(4'd1, 4'd2, 2'b00);
    checkOutput("release_txn", 16'(bus.txn_cnt), 16'h5);
    checkOutput("release_busy", 16'(bus.busy), 16'h1);
    checkOutput("release_alu_a", 16'(bus.alu_a), 16'h1);
    waitRsp("add1p2", 1'b0);
    @(negedge clk);

    // Corrupted ALU result flags rsp_err only when the checker is built in.
    forceZero = 1'b1;
    applyStimulus(4'd2, 4'd3, 2'b01);
    waitRsp("mul2x3_forced", CHECK_ON);
    forceZero = 1'b0;
    @(negedge clk);
    applyStimulus(4'd2, 4'd3, 2'b01);
    waitRsp("mul2x3_clean", 1'b0);
    @(negedge clk);

    // Reset one cycle into WAIT discards the pending operation.
    applyStimulus(4'd7, 4'd1, 2'b00);
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(negedge clk);
    checkResetValues("midwait");
    sb.delete();
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      checkOutput("no_stale_rsp", 16'(bus.rsp_valid), 16'h0);
    end
    applyStimulus(4'd1, 4'd1, 2'b00);
    waitRsp("add1p1", 1'b0);
    checkOutput("add1p1_value", 16'(bus.rsp_data), 16'h02);
    @(negedge clk);

    // 256 transactions from reset wrap txn_cnt back to 0.
    applyReset("reset1");
    for (int i = 0; i < 255; i++) begin
      applyStimulus(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                    2'($urandom_range(0, 3)));
      waitRsp("bulk", 1'b0);
    end
    @(negedge clk);
    checkOutput("txn_255", 16'(bus.txn_cnt), 16'hFF);
    applyStimulus(4'd9, 4'd9, 2'b01);
    waitRsp("mul9x9", 1'b0);
    @(negedge clk);
    checkOutput("txn_wrap", 16'(bus.txn_cnt), 16'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
